// File: rtl/ecc_op_controller.sv
// ecc_op_controller: runs encode, decode or full-channel (encode, noise, decode) operations
// against the ECC engines over req/ack handshakes. Define ECC_CTRL_TIMEOUT_EN to enable the handshake watchdog.
module ecc_op_controller #(
  parameter int AMBA_WORD = 32
`ifdef ECC_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AMBA_WORD-1:0] ctrl,
  input  logic [AMBA_WORD-1:0] data_in,
  input  logic [AMBA_WORD-1:0] codeword_width,
  input  logic [AMBA_WORD-1:0] noise,
  output logic                 enc_req,
  output logic [AMBA_WORD-1:0] enc_din,
  input  logic                 enc_ack,
  input  logic [AMBA_WORD-1:0] enc_dout,
  output logic                 dec_req,
  output logic [AMBA_WORD-1:0] dec_din,
  input  logic                 dec_ack,
  input  logic [AMBA_WORD-1:0] dec_dout,
  input  logic [1:0]           dec_nerr,
  output logic                 busy,
  output logic                 operation_done,
  output logic [AMBA_WORD-1:0] data_out,
  output logic [1:0]           num_of_errors,
  output logic                 err_cfg,
  output logic                 start_ovr
);

  typedef enum logic [2:0] {IDLE, ENC, NOISE, DEC, DONE} state_t;

  localparam logic [1:0] OP_ENC   = 2'd0;
  localparam logic [1:0] OP_DEC   = 2'd1;
  localparam logic [1:0] OP_CHAN  = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;
  localparam logic [1:0] WIDTH_BAD = 2'd3;

  state_t state, next_state;

  logic [1:0]           op_r;
  logic [AMBA_WORD-1:0] mask_r;
  logic [AMBA_WORD-1:0] noise_r;
  logic [AMBA_WORD-1:0] work_r;
  logic [AMBA_WORD-1:0] start_mask;
  logic                 cfg_bad;
  logic                 tmo_hit;
  logic                 unused_cfg_bits;

  always_comb begin
    start_mask = '0;
    case (codeword_width[1:0])
      2'd0:    start_mask[7:0]  = '1;
      2'd1:    start_mask[15:0] = '1;
      2'd2:    start_mask[31:0] = '1;
      default: start_mask       = '0;
    endcase
  end

  assign cfg_bad = (ctrl[1:0] == OP_RSVD) || (codeword_width[1:0] == WIDTH_BAD);

  // Only the low two bits of the config words carry meaning.
  assign unused_cfg_bits = ^{ctrl[AMBA_WORD-1:2], codeword_width[AMBA_WORD-1:2]};

`ifdef ECC_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  // Counter restarts whenever we leave a handshake state, so each handshake gets a full window.
  always_ff @(posedge clk) begin
    if (rst || !(state == ENC || state == DEC)) tmo_cnt <= '0;
    else                                       tmo_cnt <= tmo_cnt + CW'(1);
  end

  assign tmo_hit = (state == ENC || state == DEC) && (int'(tmo_cnt) == TIMEOUT_CYCLES - 1);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_bad)                   next_state = DONE;
          else if (ctrl[1:0] == OP_DEC)  next_state = DEC;
          else                           next_state = ENC;
        end
      end
      ENC: begin
        if (enc_ack)      next_state = (op_r == OP_CHAN) ? NOISE : DONE;
        else if (tmo_hit) next_state = DONE;
      end
      NOISE:   next_state = DEC;
      DEC: begin
        if (dec_ack || tmo_hit) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != IDLE);
    enc_req        = (state == ENC);
    dec_req        = (state == DEC);
    operation_done = (state == DONE);
    enc_din        = enc_req ? work_r : '0;
    dec_din        = dec_req ? work_r : '0;
  end

  // work_r holds the operand on its way through the engines: input, then encoded word, then noisy word.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r          <= OP_ENC;
      mask_r        <= '0;
      noise_r       <= '0;
      work_r        <= '0;
      data_out      <= '0;
      num_of_errors <= '0;
      err_cfg       <= 1'b0;
      start_ovr     <= 1'b0;
    end else begin
      if (state != IDLE && start) start_ovr <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            op_r          <= ctrl[1:0];
            mask_r        <= start_mask;
            work_r        <= data_in & start_mask;
            noise_r       <= noise & start_mask;
            data_out      <= '0;
            num_of_errors <= '0;
            err_cfg       <= cfg_bad;
            start_ovr     <= 1'b0;
          end
        end
        ENC: begin
          if (enc_ack) begin
            if (op_r == OP_CHAN) begin
              work_r <= enc_dout & mask_r;
            end else begin
              data_out      <= enc_dout & mask_r;
              num_of_errors <= '0;
            end
          end else if (tmo_hit) begin
            err_cfg <= 1'b1;
          end
        end
        NOISE: work_r <= work_r ^ noise_r;
        DEC: begin
          if (dec_ack) begin
            data_out      <= dec_dout & mask_r;
            num_of_errors <= dec_nerr;
          end else if (tmo_hit) begin
            err_cfg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
